// File: rtl/hazard_stall_unit.sv
// Hazard stall / freeze controller.
// Detects load-use and ID-branch hazards that bypassing cannot resolve, freezes the front
// of the pipeline while a multi-cycle MULT/DIV occupies EX, and counts stalled cycles.
module hazard_stall_unit #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             usesRt_ID,
    input  logic             branch_ID,
    input  logic             memRead_EX,
    input  logic             regWrite_EX,
    input  logic [4:0]       writeRegAddress_EX,
    input  logic             regWrite_MEM,
    input  logic [4:0]       writeRegAddress_MEM,
    input  logic             mdStart_EX,
    input  logic             mdDone,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExWrite,
    output logic             idExBubble,
    output logic             exMemBubble,
    output logic             mdBusy,
    output logic             mdError,
    output logic [CNT_W-1:0] stallCycles
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StMdBusy = 1'b1;

    localparam int unsigned    TmoW    = $clog2(MD_TIMEOUT);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MD_TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [TmoW-1:0]  md_cnt_q, md_cnt_d;
    logic             md_error_q, md_error_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic ex_match, mem_match;
    logic load_use, br_haz, stall, timeout_hit, freeze;

    // Source-match checks: rt only counts when the ID instruction actually reads it.
    always_comb begin
        ex_match  = (writeRegAddress_EX != 5'd0) &&
                    ((writeRegAddress_EX == rs_ID) ||
                     ((usesRt_ID || branch_ID) && (writeRegAddress_EX == rt_ID)));
        mem_match = (writeRegAddress_MEM != 5'd0) &&
                    ((writeRegAddress_MEM == rs_ID) ||
                     ((usesRt_ID || branch_ID) && (writeRegAddress_MEM == rt_ID)));
        load_use  = memRead_EX && regWrite_EX && ex_match;
        br_haz    = branch_ID && ((regWrite_EX && ex_match) || (regWrite_MEM && mem_match));
        stall     = load_use || br_haz;
        timeout_hit = (state_q == StMdBusy) && (md_cnt_q == TmoLast);
        // Freeze drops on the mdDone / timeout cycle so the op leaves EX at that edge.
        freeze    = ((state_q == StIdle) && mdStart_EX) ||
                    ((state_q == StMdBusy) && !mdDone && !timeout_hit);
    end

    // Pipeline control outputs; freeze outranks stall, reset forces free-running.
    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        idExBubble  = 1'b0;
        exMemBubble = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pcWrite     = 1'b0;
                ifIdWrite   = 1'b0;
                idExWrite   = 1'b0;
                exMemBubble = 1'b1;
            end else if (stall) begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExBubble = 1'b1;
            end
        end
    end

    // MULT/DIV occupancy FSM with timeout watchdog and saturating stall counter.
    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        md_error_d     = md_error_q;
        stall_cycles_d = stall_cycles_q;
        unique case (state_q)
            StIdle: begin
                if (mdStart_EX) begin
                    state_d  = StMdBusy;
                    md_cnt_d = '0;
                end
            end
            StMdBusy: begin
                // A done pulse on the last allowed cycle counts as a normal completion.
                if (mdDone) begin
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    state_d    = StIdle;
                    md_error_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!pcWrite && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            md_cnt_q       <= '0;
            md_error_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            md_error_q     <= md_error_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mdBusy      = (state_q == StMdBusy);
    assign mdError     = md_error_q;
    assign stallCycles = stall_cycles_q;

endmodule
